// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter_if: two-master request/response bundle plus the dmem port. rev 1.0
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  logic              busy;
  logic [1:0]        grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata,
    output busy, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata,
    input  busy, grant
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter: round-robin sharing of the data memory between two masters. rev 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          ADDR_W    = 11,
  parameter int          DATA_W    = 32
) (
  input  wire logic     clk_in,
  input  wire logic     reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [31:0] WINDOW = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;

  logic        pick_valid;
  logic        pick;
  logic [31:0] pick_off;

  // Contention goes to prio; a lone requester wins regardless of prio.
  always_comb begin
    pick_valid = bus.m0_req | bus.m1_req;
    pick       = (bus.m0_req & bus.m1_req) ? prio : bus.m1_req;
    pick_off   = (pick ? bus.m1_addr : bus.m0_addr) - BASE_ADDR;
  end

  logic              sel;
  logic              we_q;
  logic              inr_q;
  logic [ADDR_W-1:0] off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sel      <= 1'b0;
      we_q     <= 1'b0;
      inr_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == IDLE && pick_valid) begin
        sel     <= pick;
        we_q    <= pick ? bus.m1_we : bus.m0_we;
        wdata_q <= pick ? bus.m1_wdata : bus.m0_wdata;
        off_q   <= pick_off[ADDR_W-1:0];
        inr_q   <= (pick_off < WINDOW);
      end
      if (state == ACCESS) begin
        rsp_data <= (we_q | ~inr_q) ? '0 : bus.dmem_rdata;
        rsp_err  <= ~inr_q;
      end
    end
  end

  logic              ack0, ack1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy_c;
  logic [1:0]        grant_c;

  // Outputs decode from state so a reset clears them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy_c    = 1'b0;
    grant_c   = 2'b00;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = ACCESS;
          if (bus.m0_req && bus.m1_req) prio_nxt = ~prio;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        busy_c    = 1'b1;
        grant_c   = sel ? 2'b10 : 2'b01;
        mem_we    = we_q & inr_q;
        mem_addr  = off_q;
        mem_wdata = wdata_q;
      end
      RESP: begin
        state_nxt = IDLE;
        busy_c    = 1'b1;
        grant_c   = sel ? 2'b10 : 2'b01;
        if (sel) begin
          ack1   = 1'b1;
          err1   = rsp_err;
          rdata1 = rsp_data;
        end else begin
          ack0   = 1'b1;
          err0   = rsp_err;
          rdata0 = rsp_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m0_ack     = ack0;
  assign bus.m0_err     = err0;
  assign bus.m0_rdata   = rdata0;
  assign bus.m1_ack     = ack1;
  assign bus.m1_err     = err1;
  assign bus.m1_rdata   = rdata1;
  assign bus.dmem_we    = mem_we;
  assign bus.dmem_addr  = mem_addr;
  assign bus.dmem_wdata = mem_wdata;
  assign bus.busy       = busy_c;
  assign bus.grant      = grant_c;

endmodule

`default_nettype wire
